// File: rtl/vend_controller_n_pkg.sv
// Shared types and helpers for the vending-machine control core.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SUCCESS = 2'd1,
    ST_FAIL    = 2'd2
  } vend_state_e;

  localparam int BTN_INC = 0;
  localparam int BTN_DEC = 1;
  localparam int BTN_OK  = 2;
  localparam int BTN_CLR = 3;

  // Bits needed to hold any value 0..max_val.
  function automatic int bits_for(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int idx_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vend_controller_n_if.sv
// Button/switch inputs and status outputs of the vending core.
interface vend_controller_n_if
  import vend_pkg::*;
#(
  parameter int NUM_PRODUCTS = 4,
  parameter int PRICE_MAX    = 9,
  parameter int STOCK_MAX    = 9,
  parameter int COUNT_MAX    = 9,
  parameter int MONEY_MAX    = 9999
);
  localparam int MW = bits_for(MONEY_MAX);
  localparam int CW = bits_for(COUNT_MAX);
  localparam int PW = bits_for(PRICE_MAX);
  localparam int SW = bits_for(STOCK_MAX);
  localparam int IW = idx_bits(NUM_PRODUCTS);

  logic [3:0]                 btn_pulse_i;
  logic [NUM_PRODUCTS-1:0]    sw_p_i;
  logic                       sw_au_i;
  logic [MW-1:0]              money_o;
  logic [CW-1:0]              count_o;
  logic [MW-1:0]              price_to_pay_o;
  logic [IW-1:0]              sel_idx_o;
  logic                       sel_valid_o;
  logic                       sel_none_o;
  logic [PW-1:0]              sel_price_o;
  logic [SW-1:0]              sel_stock_o;
  logic [NUM_PRODUCTS*PW-1:0] price_flat_o;
  logic [NUM_PRODUCTS*SW-1:0] stock_flat_o;
  logic [1:0]                 state_o;
  logic [3:0]                 countdown_o;
  logic [NUM_PRODUCTS-1:0]    led_o;
  logic                       dispense_valid_o;
  logic [IW-1:0]              dispense_idx_o;
  logic [CW-1:0]              dispense_qty_o;
  logic                       change_valid_o;
  logic [MW-1:0]              change_amount_o;

  modport slave (
    input  btn_pulse_i, sw_p_i, sw_au_i,
    output money_o, count_o, price_to_pay_o, sel_idx_o, sel_valid_o, sel_none_o,
           sel_price_o, sel_stock_o, price_flat_o, stock_flat_o, state_o, countdown_o,
           led_o, dispense_valid_o, dispense_idx_o, dispense_qty_o, change_valid_o,
           change_amount_o
  );

  modport master (
    output btn_pulse_i, sw_p_i, sw_au_i,
    input  money_o, count_o, price_to_pay_o, sel_idx_o, sel_valid_o, sel_none_o,
           sel_price_o, sel_stock_o, price_flat_o, stock_flat_o, state_o, countdown_o,
           led_o, dispense_valid_o, dispense_idx_o, dispense_qty_o, change_valid_o,
           change_amount_o
  );

endinterface

// File: rtl/vend_controller_n_hold_timer.sv
// Result-hold timer: TICK_CYCLES prescaler plus a HOLD_TICKS countdown.
module vend_hold_timer #(
  parameter int TICK_CYCLES = 125000000,
  parameter int HOLD_TICKS  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       abort_i,
  output logic       tick_o,
  output logic       done_o,
  output logic [3:0] countdown_o
);
  localparam int TW = (TICK_CYCLES < 2) ? 1 : $clog2(TICK_CYCLES);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]    cd_q, cd_d;
  logic          active_q, active_d;

  assign tick_o      = active_q && (tick_cnt_q == TW'(TICK_CYCLES - 1));
  assign done_o      = tick_o && (cd_q == 4'd1);
  assign countdown_o = cd_q;

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    cd_d       = cd_q;
    active_d   = active_q;
    if (abort_i) begin
      active_d   = 1'b0;
      cd_d       = 4'd0;
      tick_cnt_d = '0;
    end else if (start_i) begin
      active_d   = 1'b1;
      cd_d       = 4'(HOLD_TICKS);
      tick_cnt_d = '0;
    end else if (tick_o) begin
      tick_cnt_d = '0;
      cd_d       = cd_q - 4'd1;
      if (done_o) active_d = 1'b0;
    end else if (active_q) begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      cd_q       <= 4'd0;
      active_q   <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      cd_q       <= cd_d;
      active_q   <= active_d;
    end
  end

endmodule

// File: rtl/vend_controller_n.sv
// Vending-machine control core: credit, product selection, admin editor, purchase and hold phase.
//   state      | meaning
//   ST_IDLE    | accepting buttons
//   ST_SUCCESS | purchase done, led blinking, buttons ignored until hold expires
//   ST_FAIL    | insufficient credit, buttons ignored until hold expires
module vend_controller_n
  import vend_pkg::*;
#(
  parameter int NUM_PRODUCTS = 4,
  parameter int PRICE_MAX    = 9,
  parameter int STOCK_MAX    = 9,
  parameter int COUNT_MAX    = 9,
  parameter int MONEY_MAX    = 9999,
  parameter int COIN_A       = 5,
  parameter int COIN_B       = 10,
  parameter int TICK_CYCLES  = 125000000,
  parameter int HOLD_TICKS   = 5
) (
  input logic               clk,
  input logic               rst_n,
  vend_controller_n_if.slave bus
);
  localparam int N  = NUM_PRODUCTS;
  localparam int MW = bits_for(MONEY_MAX);
  localparam int CW = bits_for(COUNT_MAX);
  localparam int PW = bits_for(PRICE_MAX);
  localparam int SW = bits_for(STOCK_MAX);
  localparam int IW = idx_bits(NUM_PRODUCTS);

  if (PRICE_MAX * COUNT_MAX > MONEY_MAX || N < 2 || N > 8 ||
      HOLD_TICKS < 1 || HOLD_TICKS > 15) begin : g_param_check
    $error("vend_controller_n: illegal parameter set");
  end

  vend_state_e            state_q, state_d;
  logic [MW-1:0]          money_q, money_d;
  logic [CW-1:0]          count_q, count_d;
  logic [N-1:0][PW-1:0]   price_q, price_d;
  logic [N-1:0][SW-1:0]   stock_q, stock_d;
  logic [N-1:0]           led_q, led_d;
  logic                   dv_q, dv_d, cv_q, cv_d;
  logic [IW-1:0]          didx_q, didx_d;
  logic [CW-1:0]          dqty_q, dqty_d;
  logic [MW-1:0]          camt_q, camt_d;
  logic [IW-1:0]          prev_idx_q;
  logic                   prev_valid_q, prev_au_q;

  logic [IW-1:0] sel_idx;
  logic          sel_valid, sel_none;
  logic [PW-1:0] sel_price;
  logic [SW-1:0] sel_stock;
  logic [MW-1:0] price_to_pay;
  logic [3:0]    btn;
  logic          au, au_rise, count_clr;
  logic          hold_start, hold_abort, hold_tick, hold_done;
  logic [3:0]    countdown;

  always_comb begin
    sel_idx   = '0;
    sel_none  = (bus.sw_p_i == '0);
    sel_valid = $onehot(bus.sw_p_i);
    for (int i = 0; i < N; i++) begin
      if (sel_valid && bus.sw_p_i[i]) sel_idx = IW'(i);
    end
  end

  assign sel_price    = price_q[sel_idx];
  assign sel_stock    = stock_q[sel_idx];
  assign price_to_pay = MW'(sel_price) * MW'(count_q);
  // Isolate the lowest set bit: btn0 has top priority.
  assign btn          = bus.btn_pulse_i & ~(bus.btn_pulse_i - 4'd1);
  assign au           = bus.sw_au_i;
  assign au_rise      = au && !prev_au_q;
  assign count_clr    = (sel_idx != prev_idx_q) || (prev_valid_q && !sel_valid) || au;

  always_comb begin
    state_d    = state_q;
    money_d    = money_q;
    count_d    = count_q;
    price_d    = price_q;
    stock_d    = stock_q;
    led_d      = led_q;
    dv_d       = 1'b0;
    didx_d     = didx_q;
    dqty_d     = dqty_q;
    cv_d       = 1'b0;
    camt_d     = camt_q;
    hold_start = 1'b0;
    hold_abort = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!au && sel_none) begin
          if (btn[BTN_INC]) begin
            if (int'(money_q) + COIN_A <= MONEY_MAX) money_d = money_q + MW'(COIN_A);
          end else if (btn[BTN_DEC]) begin
            if (int'(money_q) + COIN_B <= MONEY_MAX) money_d = money_q + MW'(COIN_B);
          end else if (btn[BTN_OK] && money_q != '0) begin
            cv_d    = 1'b1;
            camt_d  = money_q;
            money_d = '0;
          end
        end else if (!au && sel_valid) begin
          if (btn[BTN_INC]) begin
            if (int'(count_q) < COUNT_MAX && int'(count_q) < int'(sel_stock) && sel_price != '0)
              count_d = count_q + CW'(1);
          end else if (btn[BTN_DEC]) begin
            if (count_q != '0) count_d = count_q - CW'(1);
          end else if (btn[BTN_OK] && count_q != '0) begin
            hold_start = 1'b1;
            if (money_q >= price_to_pay) begin
              money_d          = money_q - price_to_pay;
              stock_d[sel_idx] = sel_stock - SW'(count_q);
              count_d          = '0;
              dv_d             = 1'b1;
              didx_d           = sel_idx;
              dqty_d           = count_q;
              led_d            = N'(1) << sel_idx;
              state_d          = ST_SUCCESS;
            end else begin
              state_d = ST_FAIL;
            end
          end else if (btn[BTN_CLR]) begin
            count_d = '0;
          end
        end else if (au && sel_valid) begin
          if (btn[BTN_INC]) begin
            if (int'(sel_price) < PRICE_MAX) price_d[sel_idx] = sel_price + PW'(1);
          end else if (btn[BTN_DEC]) begin
            if (sel_price > PW'(1)) price_d[sel_idx] = sel_price - PW'(1);
          end else if (btn[BTN_OK]) begin
            if (int'(sel_stock) < STOCK_MAX) stock_d[sel_idx] = sel_stock + SW'(1);
          end else if (btn[BTN_CLR]) begin
            price_d[sel_idx] = '0;
            stock_d[sel_idx] = '0;
          end
        end
      end
      ST_SUCCESS, ST_FAIL: begin
        if (au_rise) begin
          hold_abort = 1'b1;
          state_d    = ST_IDLE;
          led_d      = '0;
        end else if (hold_done) begin
          state_d = ST_IDLE;
          led_d   = '0;
        end else if (hold_tick && state_q == ST_SUCCESS) begin
          led_d = (led_q == '0) ? (N'(1) << didx_q) : '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (count_clr) count_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      money_q      <= '0;
      count_q      <= '0;
      price_q      <= '0;
      stock_q      <= '0;
      led_q        <= '0;
      dv_q         <= 1'b0;
      didx_q       <= '0;
      dqty_q       <= '0;
      cv_q         <= 1'b0;
      camt_q       <= '0;
      prev_idx_q   <= '0;
      prev_valid_q <= 1'b0;
      prev_au_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      money_q      <= money_d;
      count_q      <= count_d;
      price_q      <= price_d;
      stock_q      <= stock_d;
      led_q        <= led_d;
      dv_q         <= dv_d;
      didx_q       <= didx_d;
      dqty_q       <= dqty_d;
      cv_q         <= cv_d;
      camt_q       <= camt_d;
      prev_idx_q   <= sel_idx;
      prev_valid_q <= sel_valid;
      prev_au_q    <= au;
    end
  end

  vend_hold_timer #(
    .TICK_CYCLES (TICK_CYCLES),
    .HOLD_TICKS  (HOLD_TICKS)
  ) u_hold_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (hold_start),
    .abort_i     (hold_abort),
    .tick_o      (hold_tick),
    .done_o      (hold_done),
    .countdown_o (countdown)
  );

  assign bus.money_o          = money_q;
  assign bus.count_o          = count_q;
  assign bus.price_to_pay_o   = price_to_pay;
  assign bus.sel_idx_o        = sel_idx;
  assign bus.sel_valid_o      = sel_valid;
  assign bus.sel_none_o       = sel_none;
  assign bus.sel_price_o      = sel_price;
  assign bus.sel_stock_o      = sel_stock;
  assign bus.price_flat_o     = price_q;
  assign bus.stock_flat_o     = stock_q;
  assign bus.state_o          = state_q;
  assign bus.countdown_o      = countdown;
  assign bus.led_o            = led_q;
  assign bus.dispense_valid_o = dv_q;
  assign bus.dispense_idx_o   = didx_q;
  assign bus.dispense_qty_o   = dqty_q;
  assign bus.change_valid_o   = cv_q;
  assign bus.change_amount_o  = camt_q;

endmodule
